// File: rtl/vram_writer.sv
// ---------------------------------------------------------------------------
// vram_writer
//
// Purpose:
//   CPU-side writer for the dual-port video RAM. It watches Z80 memory-write
//   cycles, picks out writes that land in the screen area of bank 5 (normal
//   screen) or bank 7 (shadow screen, 128K map only), and queues them in a
//   small FIFO. The FIFO drains into the VRAM write port on cycles where the
//   video controller is not using the RAM.
//
// Ports:
//   CLK          in   14MHz master clock
//   nRESET       in   synchronous active-low reset
//   addr         in   CPU address bus [15:0]
//   din          in   CPU data-out bus [7:0]
//   nMREQ        in   CPU memory request, active low
//   nWR          in   CPU write strobe, active low
//   nRFSH        in   CPU refresh, active low
//   m128         in   128K memory map enabled
//   page_ram     in   RAM bank mapped at C000-FFFF [2:0]
//   vram_busy    in   video controller owns the VRAM this cycle
//   ovf_clr      in   clears the sticky overflow flag
//   vram_waddr   out  {bank7, offset[12:0]}
//   vram_wdata   out  write data
//   vram_we      out  one-CLK write pulse
//   fifo_level   out  current FIFO occupancy
//   overflow     out  sticky flag: a screen write was dropped
//
// Configuration macro:
//   VRAM_WRITER_COALESCE_EN - when defined, a write to the same {bank,offset}
//   as the newest queued entry overwrites that entry's data instead of
//   allocating a new slot.
// ---------------------------------------------------------------------------
module vram_writer #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [12:0] SCREEN_LIMIT = 13'h1B00
) (
    input  logic                          CLK,
    input  logic                          nRESET,
    input  logic [15:0]                   addr,
    input  logic [7:0]                    din,
    input  logic                          nMREQ,
    input  logic                          nWR,
    input  logic                          nRFSH,
    input  logic                          m128,
    input  logic [2:0]                    page_ram,
    input  logic                          vram_busy,
    input  logic                          ovf_clr,
    output logic [13:0]                   vram_waddr,
    output logic [7:0]                    vram_wdata,
    output logic                          vram_we,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 22;

    // Write strobe detection and screen decode
    logic          nwr_q;
    logic          strobe;
    logic          screen_ok;
    logic          bank5_hit;
    logic          bank7_hit;
    logic          hit;
    logic [EW-1:0] entry_in;

    // Capture stage between decode and FIFO
    logic          push_q, push_d;
    logic [EW-1:0] entry_q, entry_d;

    // FIFO storage and control
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          mem_we;
    logic [PW-1:0] mem_wptr;
    logic          pop;
    logic          full;
    logic          alloc;
    logic          coalesce;
    logic          ovf_set;

    // Output registers
    logic          we_q, we_d;
    logic [13:0]   waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          ovf_q, ovf_d;

    // A falling edge of nWR during a real memory cycle (not refresh) marks
    // exactly one write per CPU cycle, however long nWR stays low.
    assign strobe    = nwr_q & ~nWR & ~nMREQ & nRFSH;
    assign screen_ok = ~addr[13] & (addr[12:0] < SCREEN_LIMIT);
    assign bank5_hit = (addr[15:14] == 2'b01) |
                       ((addr[15:14] == 2'b11) & m128 & (page_ram == 3'd5));
    assign bank7_hit = (addr[15:14] == 2'b11) & m128 & (page_ram == 3'd7);
    assign hit       = strobe & screen_ok & (bank5_hit | bank7_hit);
    assign entry_in  = {bank7_hit, addr[12:0], din};

    assign pop  = (count_q != '0) & ~vram_busy;
    assign full = (count_q == LW'(FIFO_DEPTH));

    // Coalescing targets the newest entry, but never one that leaves the
    // FIFO on this same edge, since its old data is already on its way out.
`ifdef VRAM_WRITER_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr = wr_ptr_q - 1'b1;
    assign coalesce = push_q & (count_q != '0) &
                      ~(pop & (count_q == LW'(1))) &
                      (mem_q[tail_ptr][EW-1:8] == entry_q[EW-1:8]);
`else
    assign coalesce = 1'b0;
`endif

    always_comb begin
        push_d   = hit;
        entry_d  = hit ? entry_in : entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        mem_we   = 1'b0;
        mem_wptr = wr_ptr_q;
        alloc    = 1'b0;
        ovf_set  = 1'b0;

        if (pop) begin
            we_d     = 1'b1;
            waddr_d  = mem_q[rd_ptr_q][EW-1:8];
            wdata_d  = mem_q[rd_ptr_q][7:0];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // A full FIFO still accepts a push when a pop frees a slot this edge.
        if (push_q) begin
            if (coalesce) begin
`ifdef VRAM_WRITER_COALESCE_EN
                mem_we   = 1'b1;
                mem_wptr = tail_ptr;
`endif
            end else if (!full || pop) begin
                mem_we   = 1'b1;
                alloc    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end else begin
                ovf_set  = 1'b1;
            end
        end

        count_d = count_q + LW'(alloc) - LW'(pop);

        // A new drop beats a simultaneous clear.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            nwr_q    <= 1'b1;
            push_q   <= 1'b0;
            entry_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            nwr_q    <= nWR;
            push_q   <= push_d;
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_wptr] <= entry_q;
        end
    end

    assign vram_we    = we_q;
    assign vram_waddr = waddr_q;
    assign vram_wdata = wdata_q;
    assign fifo_level = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_vram_writer.sv
// ---------------------------------------------------------------------------
// tb_vram_writer
//
// Directed testbench for vram_writer (FIFO_DEPTH=4, default build).
// Drives Z80-style write cycles and checks drain timing, decode, overflow,
// same-edge push/pop, flag clear priority and reset flushing.
// ---------------------------------------------------------------------------
module tb_vram_writer;

    logic        clk;
    logic        nReset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        nMreq;
    logic        nWr;
    logic        nRfsh;
    logic        m128;
    logic [2:0]  pageRam;
    logic        vramBusy;
    logic        ovfClr;
    logic [13:0] vramWaddr;
    logic [7:0]  vramWdata;
    logic        vramWe;
    logic [2:0]  fifoLevel;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    vram_writer #(
        .FIFO_DEPTH   (4),
        .SCREEN_LIMIT (13'h1B00)
    ) dut (
        .CLK        (clk),
        .nRESET     (nReset),
        .addr       (addr),
        .din        (din),
        .nMREQ      (nMreq),
        .nWR        (nWr),
        .nRFSH      (nRfsh),
        .m128       (m128),
        .page_ram   (pageRam),
        .vram_busy  (vramBusy),
        .ovf_clr    (ovfClr),
        .vram_waddr (vramWaddr),
        .vram_wdata (vramWdata),
        .vram_we    (vramWe),
        .fifo_level (fifoLevel),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One CPU write: idle edge so nWR history reads high, then nWR low across
    // two edges. Returns just after the edge following the strobe edge,
    // i.e. with the entry already in the FIFO.
    task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d);
        tick();
        addr  = a;
        din   = d;
        nMreq = 1'b0;
        nWr   = 1'b0;
        tick();
        tick();
        nWr   = 1'b1;
        nMreq = 1'b1;
    endtask

    initial begin
        nReset   = 1'b0;
        addr     = 16'h0000;
        din      = 8'h00;
        nMreq    = 1'b1;
        nWr      = 1'b1;
        nRfsh    = 1'b1;
        m128     = 1'b0;
        pageRam  = 3'd0;
        vramBusy = 1'b0;
        ovfClr   = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_we",    32'(vramWe),    32'h0);
        checkOutput("rst_waddr", 32'(vramWaddr), 32'h0);
        checkOutput("rst_wdata", 32'(vramWdata), 32'h0);
        checkOutput("rst_level", 32'(fifoLevel), 32'h0);
        checkOutput("rst_ovf",   32'(overflow),  32'h0);
        nReset = 1'b1;
        tick();

        // Single write 0x4000 <= 0xAA, cycle-exact latency, nWR held long
        $display("[TB] basic write latency");
        addr  = 16'h4000;
        din   = 8'hAA;
        nMreq = 1'b0;
        nWr   = 1'b0;
        tick();
        checkOutput("t1_n_we",     32'(vramWe),    32'h0);
        checkOutput("t1_n_level",  32'(fifoLevel), 32'h0);
        tick();
        checkOutput("t1_n1_we",    32'(vramWe),    32'h0);
        checkOutput("t1_n1_level", 32'(fifoLevel), 32'h1);
        tick();
        checkOutput("t1_n2_we",    32'(vramWe),    32'h1);
        checkOutput("t1_n2_waddr", 32'(vramWaddr), 32'h0000);
        checkOutput("t1_n2_wdata", 32'(vramWdata), 32'hAA);
        checkOutput("t1_n2_level", 32'(fifoLevel), 32'h0);
        tick();
        checkOutput("t1_n3_we",    32'(vramWe),    32'h0);
        tick();
        checkOutput("t1_hold_we",    32'(vramWe),    32'h0);
        checkOutput("t1_hold_level", 32'(fifoLevel), 32'h0);
        checkOutput("t1_hold_waddr", 32'(vramWaddr), 32'h0000);
        nWr   = 1'b1;
        nMreq = 1'b1;

        // Bank 7 write via the 128K map
        $display("[TB] bank 7 write");
        m128    = 1'b1;
        pageRam = 3'd7;
        applyStimulus(16'hC123, 8'h5C);
        tick();
        checkOutput("t2_we",    32'(vramWe),    32'h1);
        checkOutput("t2_waddr", 32'(vramWaddr), 32'h2123);
        checkOutput("t2_wdata", 32'(vramWdata), 32'h5C);

        // Bank 5 paged at C000
        pageRam = 3'd5;
        applyStimulus(16'hC010, 8'h77);
        tick();
        checkOutput("t2b_we",    32'(vramWe),    32'h1);
        checkOutput("t2b_waddr", 32'(vramWaddr), 32'h0010);
        checkOutput("t2b_wdata", 32'(vramWdata), 32'h77);

        // Ignored writes: past screen limit, bank 2, unpaged bank, refresh
        $display("[TB] ignored writes");
        pageRam = 3'd0;
        applyStimulus(16'h5B00, 8'h11);
        tick();
        checkOutput("t3_limit_we",  32'(vramWe),    32'h0);
        checkOutput("t3_limit_lvl", 32'(fifoLevel), 32'h0);
        applyStimulus(16'h8000, 8'h22);
        tick();
        checkOutput("t3_8000_we",   32'(vramWe),    32'h0);
        checkOutput("t3_8000_lvl",  32'(fifoLevel), 32'h0);
        applyStimulus(16'hC000, 8'h33);
        tick();
        checkOutput("t3_c000_we",   32'(vramWe),    32'h0);
        checkOutput("t3_c000_lvl",  32'(fifoLevel), 32'h0);
        m128    = 1'b0;
        pageRam = 3'd5;
        applyStimulus(16'hC000, 8'h34);
        tick();
        checkOutput("t3_48k_we",    32'(vramWe),    32'h0);
        nRfsh = 1'b0;
        applyStimulus(16'h4000, 8'h44);
        tick();
        checkOutput("t3_rfsh_we",   32'(vramWe),    32'h0);
        checkOutput("t3_rfsh_lvl",  32'(fifoLevel), 32'h0);
        nRfsh   = 1'b1;
        pageRam = 3'd0;

        // Overflow while busy, then ordered drain
        $display("[TB] overflow and drain");
        vramBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(16'h4000 + 16'(i), 8'h10 + 8'(i));
        end
        tick();
        checkOutput("t4_level", 32'(fifoLevel), 32'h4);
        checkOutput("t4_ovf",   32'(overflow),  32'h1);
        checkOutput("t4_we",    32'(vramWe),    32'h0);
        vramBusy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t4_drain%0d_we", i),    32'(vramWe),    32'h1);
            checkOutput($sformatf("t4_drain%0d_waddr", i), 32'(vramWaddr), 32'(i));
            checkOutput($sformatf("t4_drain%0d_wdata", i), 32'(vramWdata), 32'h10 + 32'(i));
        end
        tick();
        checkOutput("t4_end_we",    32'(vramWe),    32'h0);
        checkOutput("t4_end_level", 32'(fifoLevel), 32'h0);

        // Clear the overflow flag
        ovfClr = 1'b1;
        tick();
        ovfClr = 1'b0;
        checkOutput("t5_clr_ovf", 32'(overflow), 32'h0);

        // Push and pop on the same edge with the FIFO full
        $display("[TB] full push+pop");
        vramBusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h4100 + 16'(i), 8'h20 + 8'(i));
        end
        checkOutput("t5_full_level", 32'(fifoLevel), 32'h4);
        tick();
        addr  = 16'h4104;
        din   = 8'h24;
        nMreq = 1'b0;
        nWr   = 1'b0;
        tick();
        vramBusy = 1'b0;
        tick();
        checkOutput("t5_pp_level", 32'(fifoLevel), 32'h4);
        checkOutput("t5_pp_ovf",   32'(overflow),  32'h0);
        checkOutput("t5_pp_we",    32'(vramWe),    32'h1);
        checkOutput("t5_pp_waddr", 32'(vramWaddr), 32'h0100);
        checkOutput("t5_pp_wdata", 32'(vramWdata), 32'h20);
        nWr   = 1'b1;
        nMreq = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            checkOutput($sformatf("t5_drain%0d_waddr", i), 32'(vramWaddr), 32'h100 + 32'(i));
            checkOutput($sformatf("t5_drain%0d_wdata", i), 32'(vramWdata), 32'h20 + 32'(i));
        end
        tick();
        checkOutput("t5_end_level", 32'(fifoLevel), 32'h0);

        // Overflow and clear on the same edge: set wins
        $display("[TB] overflow set beats clear");
        vramBusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h4200 + 16'(i), 8'h30 + 8'(i));
        end
        tick();
        addr  = 16'h4204;
        din   = 8'h34;
        nMreq = 1'b0;
        nWr   = 1'b0;
        tick();
        ovfClr = 1'b1;
        tick();
        checkOutput("t6_setwins_ovf", 32'(overflow),  32'h1);
        checkOutput("t6_setwins_lvl", 32'(fifoLevel), 32'h4);
        nWr   = 1'b1;
        nMreq = 1'b1;
        tick();
        checkOutput("t6_clr_ovf", 32'(overflow), 32'h0);
        ovfClr   = 1'b0;
        vramBusy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        checkOutput("t6_end_level", 32'(fifoLevel), 32'h0);

        // Reset with pending entries flushes them
        $display("[TB] reset flush");
        vramBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h4300 + 16'(i), 8'h40 + 8'(i));
        end
        checkOutput("t7_pending", 32'(fifoLevel), 32'h3);
        nReset = 1'b0;
        tick();
        checkOutput("t7_rst_level", 32'(fifoLevel), 32'h0);
        checkOutput("t7_rst_we",    32'(vramWe),    32'h0);
        checkOutput("t7_rst_waddr", 32'(vramWaddr), 32'h0);
        nReset   = 1'b1;
        vramBusy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("t7_post%0d_we", i), 32'(vramWe), 32'h0);
        end
        checkOutput("t7_post_level", 32'(fifoLevel), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- CPU-side writer for the dual-port video RAM; the video controller is the reader on the other port.
- Snoops Z80 memory-write cycles and decodes the screen areas of bank 5 (normal screen) and bank 7 (shadow screen, 128K only).
- Queues qualifying writes in a small FIFO and drains them into the VRAM write port in cycles the video fetch slot is idle.
- Lets the video controller's read port stay contention-free while CPU screen writes are never lost at normal rates.

Parameters:
- FIFO_DEPTH, 4, number of queued writes; power of two, 2..16.
- SCREEN_LIMIT, 13'h1B00, first bank offset NOT mirrored; offsets 0..SCREEN_LIMIT-1 are pixel+attribute bytes.

Ports:
- CLK  in  1  14MHz master clock.
- nRESET  in  1  synchronous active-low reset.
- addr  in  16  CPU address bus.
- din  in  8  CPU data-out bus.
- nMREQ  in  1  CPU memory request, active low.
- nWR  in  1  CPU write strobe, active low.
- nRFSH  in  1  CPU refresh, active low.
- m128  in  1  128K memory map enabled.
- page_ram  in  3  RAM bank mapped at C000-FFFF.
- vram_busy  in  1  video controller owns the VRAM this cycle; no write allowed.
- ovf_clr  in  1  clears the overflow flag.
- vram_waddr  out  14  write address: bit13 = bank 7 select, bits12:0 = offset.
- vram_wdata  out  8  write data.
- vram_we  out  1  one-CLK write pulse.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (nRESET low at CLK edge):
  - vram_we=0, vram_waddr=0, vram_wdata=0, overflow=0, fifo_level=0.
  - FIFO flushed and nWR history set to 1.
  - Reset mid-drain discards all pending entries; vram_we is low after the reset edge.
- Write strobe detection:
  - nWR_q is nWR registered each CLK.
  - strobe = nWR_q & ~nWR & ~nMREQ & nRFSH.
  - Exactly one strobe per CPU write cycle; a nWR held low for many CLKs gives no repeats.
- Decode, on the strobe cycle only:
  - addr[15:14]=01 -> bank 5.
  - addr[15:14]=11 & m128 & page_ram=5 -> bank 5.
  - addr[15:14]=11 & m128 & page_ram=7 -> bank 7.
  - Anything else is ignored.
  - Also required: addr[13]=0 and addr[12:0] < SCREEN_LIMIT; otherwise ignored.
- Entry format is {bank7, addr[12:0], din}, with din sampled on the strobe cycle.
- FIFO:
  - push = strobe & decode hit.
  - pop = non-empty & ~vram_busy.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is updated on the same edge as the pointers.
- Drain:
  - On an edge where pop=1, register the head entry to vram_waddr/vram_wdata and set vram_we=1. Otherwise vram_we=0.
  - vram_waddr/vram_wdata hold their last value when idle.
  - Back-to-back pops are allowed every CLK while vram_busy=0.
- Latency: strobe at edge N -> entry present after N+1 -> vram_we high after edge N+2 at the earliest (busy low).
- Boundary cases:
  - Empty with push and no pop: level +1.
  - Full with push, no pop: entry dropped, overflow <= 1, level unchanged.
  - Full with push and pop on the same edge: both succeed, level stays FIFO_DEPTH.
  - Empty with pop: not possible, since pop requires non-empty.
  - ovf_clr and a new overflow on the same edge: overflow stays 1 (set wins).
- vram_busy high for arbitrary time holds the FIFO contents and keeps vram_we=0.
- Write ordering is strictly FIFO.

Optional Feature:
- Macro: VRAM_WRITER_COALESCE_EN.
- Defined: a push whose {bank7, addr} equals the FIFO tail entry (most recent, not yet popped) overwrites that entry's data instead of allocating. Level is unchanged and overflow cannot be set by such a push. This also applies when the FIFO is full.
- Not defined: every push allocates a new entry.

Test Plan:
- Write 0x4000<=0xAA, busy=0 -> vram_we pulse 2 CLKs after the strobe, waddr=0x0000, wdata=0xAA, level back to 0.
- m128=1, page_ram=7, write 0xC123<=0x5C -> waddr=0x2123, wdata=0x5C.
- Writes to 0x5B00, 0x8000, and 0xC000 with page_ram=0, plus an nRFSH-low cycle -> no vram_we, level stays 0.
- vram_busy=1, 5 screen writes with FIFO_DEPTH=4 -> level=4, overflow=1. Release busy -> exactly 4 consecutive vram_we pulses carrying the first 4 writes in order.
- Push and pop on the same edge with FIFO full -> level stays 4, overflow stays 0. Then pulse ovf_clr after an overflow -> overflow=0.
- nRESET low with 3 pending entries -> level=0, vram_we=0, and no further writes after reset is released.
